// File: rtl/led_cmd_responder_pkg.sv
// Shared constants, state encoding and reply buffer type for the LED command responder.
`timescale 1ns/1ps
package led_cmd_pkg;

    localparam logic [7:0] CMD_L    = 8'h4C;
    localparam logic [7:0] CMD_R    = 8'h52;
    localparam logic [7:0] CMD_V    = 8'h56;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_Q  = 8'h3F;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_0  = 8'h30;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARG   = 2'd1,
        REPLY = 2'd2
    } state_t;

    // Element 0 is the first byte sent on the IN stream.
    typedef logic [3:0][7:0] reply_buf_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
        if (nibble <= 4'd9) begin
            return 8'h30 + {4'h0, nibble};
        end
        return 8'h37 + {4'h0, nibble};
    endfunction

endpackage

// File: rtl/led_cmd_responder_if.sv
// CDC byte-stream pair: OUT carries host bytes in, IN carries reply bytes back.
// valid/ready: a byte transfers on a rising edge where both are high; once valid is
// raised the sender holds data and valid stable until the transfer happens.
`timescale 1ns/1ps
interface led_cmd_responder_if;
    logic [7:0] out_data_i;
    logic       out_valid_i;
    logic       out_ready_o;
    logic [7:0] in_data_o;
    logic       in_valid_o;
    logic       in_ready_i;

    modport master (
        output out_data_i,
        output out_valid_i,
        input  out_ready_o,
        input  in_data_o,
        input  in_valid_o,
        output in_ready_i
    );

    modport slave (
        input  out_data_i,
        input  out_valid_i,
        output out_ready_o,
        output in_data_o,
        output in_valid_o,
        input  in_ready_i
    );
endinterface

// File: rtl/led_cmd_responder_reply_tx.sv
// Parallel-load reply buffer that streams up to four bytes out on the IN handshake.
`timescale 1ns/1ps
module reply_tx
    import led_cmd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  reply_buf_t load_data_i,
    input  logic [2:0] load_len_i,
    input  logic       in_ready_i,
    output logic [7:0] in_data_o,
    output logic       in_valid_o,
    output logic       done_o
);

    reply_buf_t rbuf_q;
    logic [2:0] remain_q;
    logic       valid_q;
    logic       consume;

    assign consume    = valid_q && in_ready_i;
    assign in_data_o  = rbuf_q[0];
    assign in_valid_o = valid_q;
    assign done_o     = consume && (remain_q == 3'd1);

    // Consumed bytes shift out so the next one lands on in_data_o at the same edge.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rbuf_q   <= '0;
            remain_q <= 3'd0;
            valid_q  <= 1'b0;
        end else if (clear_i) begin
            rbuf_q   <= '0;
            remain_q <= 3'd0;
            valid_q  <= 1'b0;
        end else if (load_i) begin
            rbuf_q   <= load_data_i;
            remain_q <= load_len_i;
            valid_q  <= (load_len_i != 3'd0);
        end else if (consume) begin
            rbuf_q   <= rbuf_q >> 8;
            remain_q <= remain_q - 3'd1;
            valid_q  <= (remain_q != 3'd1);
        end
    end

endmodule

// File: rtl/led_cmd_responder.sv
// Parses single-letter host commands, drives the RGB LED enables and answers in ASCII.
`timescale 1ns/1ps
module led_cmd_responder
    import led_cmd_pkg::*;
#(
    parameter logic [7:0]  VERSION     = 8'h01,
    parameter logic [2:0]  LED_RESET   = 3'b000,
    parameter int unsigned ARG_TIMEOUT = 12_000_000
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              configured_i,
    led_cmd_responder_if.slave cdc,
    output logic [2:0]        led_o,
    output state_t            state_o
);

    localparam logic [23:0] TIMEOUT_LAST = 24'(ARG_TIMEOUT - 1);

    state_t      state_q;
    logic [23:0] cnt_q;
    logic [2:0]  led_q;
    logic        accept;
    logic [7:0]  rx;
    logic        is_digit;
    logic        timeout_hit;
    logic        tx_load;
    reply_buf_t  tx_data;
    logic [2:0]  tx_len;
    logic        tx_done;

    assign cdc.out_ready_o = configured_i && (state_q != REPLY);
    assign accept          = cdc.out_valid_i && cdc.out_ready_o;
    assign rx              = cdc.out_data_i;
    assign is_digit        = (rx[7:3] == 5'b00110);
    assign timeout_hit     = configured_i && (state_q == ARG) && !accept
                             && (cnt_q == TIMEOUT_LAST);
    assign led_o           = led_q;
    assign state_o         = state_q;

    // Reply selection must be combinational so the first byte is valid one edge after acceptance.
    always_comb begin
        tx_load = 1'b0;
        tx_len  = 3'd3;
        tx_data = {8'h00, ASCII_LF, ASCII_CR, ASCII_Q};
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (rx)
                        CMD_L, ASCII_CR, ASCII_LF: tx_load = 1'b0;
                        CMD_R: begin
                            tx_load    = 1'b1;
                            tx_data[0] = ASCII_0 + {5'd0, led_q};
                        end
                        CMD_V: begin
                            tx_load = 1'b1;
                            tx_len  = 3'd4;
                            tx_data = {ASCII_LF, ASCII_CR,
                                       hex_ascii(VERSION[3:0]), hex_ascii(VERSION[7:4])};
                        end
                        default: tx_load = 1'b1;
                    endcase
                end
            end
            ARG: begin
                if (accept) begin
                    tx_load = 1'b1;
                    if (is_digit) begin
                        tx_data[0] = ASCII_K;
                    end
                end else if (timeout_hit) begin
                    tx_load = 1'b1;
                end
            end
            default: tx_load = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= 24'd0;
            led_q   <= LED_RESET;
        end else if (!configured_i) begin
            state_q <= IDLE;
            cnt_q   <= 24'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (rx == CMD_L) begin
                            state_q <= ARG;
                            cnt_q   <= 24'd0;
                        end else if (rx != ASCII_CR && rx != ASCII_LF) begin
                            state_q <= REPLY;
                        end
                    end
                end
                ARG: begin
                    if (accept) begin
                        if (is_digit) begin
                            led_q <= rx[2:0];
                        end
                        state_q <= REPLY;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q <= REPLY;
                    end else begin
                        cnt_q <= cnt_q + 24'd1;
                    end
                end
                REPLY: begin
                    if (tx_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    reply_tx u_reply_tx (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .clear_i     (!configured_i),
        .load_i      (tx_load),
        .load_data_i (tx_data),
        .load_len_i  (tx_len),
        .in_ready_i  (cdc.in_ready_i),
        .in_data_o   (cdc.in_data_o),
        .in_valid_o  (cdc.in_valid_o),
        .done_o      (tx_done)
    );

endmodule

// File: tb/tb_led_cmd_responder.sv
// Directed bench for led_cmd_responder: commands, stalls, timeout, abort and reset.
`timescale 1ns/1ps
module tb_led_cmd_responder;
  import led_cmd_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic       configured;
  logic [2:0] led;
  state_t     dbg_state;
  int         tests_run = 0;
  int         tests_failed = 0;
  logic [7:0] exp_q[$];

  led_cmd_responder_if cdc();

  led_cmd_responder #(
    .VERSION     (8'hA7),
    .LED_RESET   (3'b000),
    .ARG_TIMEOUT (16)
  ) dut (
    .clk_i        (clk),
    .rstn_i       (rstn),
    .configured_i (configured),
    .cdc          (cdc),
    .led_o        (led),
    .state_o      (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // driver: present one byte at a negedge, accepted on the following posedge
  task automatic send_byte(input logic [7:0] b);
    tests_run++;
    if (cdc.out_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL send_ready byte=%h out_ready=%b expected 1", b, cdc.out_ready_o);
    end
    cdc.out_data_i  = b;
    cdc.out_valid_i = 1'b1;
    @(negedge clk);
    cdc.out_valid_i = 1'b0;
  endtask

  // scoreboard: drain the IN stream against exp_q; mode 0 = always ready, 1 = ready 1-of-3
  task automatic sb_drain(input string name, input int mode, output int cycles);
    int         k = 0;
    logic       stalled = 1'b0;
    logic       rdy;
    logic [7:0] held = 8'h00;
    logic [7:0] exp;
    while (exp_q.size() != 0 && k < 60) begin
      rdy = (mode == 0) ? 1'b1 : ((k % 3) == 2);
      cdc.in_ready_i = rdy;
      if (stalled) begin
        tests_run++;
        if (cdc.in_valid_o !== 1'b1 || cdc.in_data_o !== held) begin
          tests_failed++;
          $display("FAIL %s_stable valid=%b data=%h expected valid=1 data=%h",
                   name, cdc.in_valid_o, cdc.in_data_o, held);
        end
      end
      if (cdc.in_valid_o === 1'b1 && rdy) begin
        exp = exp_q.pop_front();
        tests_run++;
        if (cdc.in_data_o !== exp) begin
          tests_failed++;
          $display("FAIL %s_byte got=%h expected=%h", name, cdc.in_data_o, exp);
        end
        stalled = 1'b0;
      end else if (cdc.in_valid_o === 1'b1) begin
        stalled = 1'b1;
        held    = cdc.in_data_o;
      end
      k++;
      @(negedge clk);
    end
    cdc.in_ready_i = 1'b0;
    cycles = k;
    if (exp_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s_timeout bytes_left=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn            = 1'b0;
    configured      = 1'b0;
    cdc.out_data_i  = 8'h00;
    cdc.out_valid_i = 1'b0;
    cdc.in_ready_i  = 1'b0;
    #12;
    tests_run++;
    if (cdc.out_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_unconf got=%b expected 0", cdc.out_ready_o);
    end
    configured = 1'b1;
    #1;
    tests_run++;
    if (cdc.in_valid_o !== 1'b0 || cdc.in_data_o !== 8'h00 || led !== 3'b000
        || cdc.out_ready_o !== 1'b1 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_values valid=%b data=%h led=%b ready=%b state=%0d expected 0 00 000 1 0",
               cdc.in_valid_o, cdc.in_data_o, led, cdc.out_ready_o, dbg_state);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_led_set();
    int cyc;
    send_byte(CMD_L);
    tests_run++;
    if (dbg_state !== ARG || cdc.in_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL led_set_arg state=%0d valid=%b expected 1 0", dbg_state, cdc.in_valid_o);
    end
    send_byte(8'h35);
    tests_run++;
    if (led !== 3'b101 || cdc.in_valid_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL led_set_led led=%b valid=%b expected 101 1", led, cdc.in_valid_o);
    end
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    sb_drain("led_set", 0, cyc);
    tests_run++;
    if (cyc != 3) begin
      tests_failed++;
      $display("FAIL led_set_b2b cycles=%0d expected 3", cyc);
    end
    tests_run++;
    if (cdc.in_valid_o !== 1'b0 || cdc.out_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL led_set_after valid=%b ready=%b expected 0 1", cdc.in_valid_o, cdc.out_ready_o);
    end
  endtask

  task automatic test_read_stall();
    int cyc;
    send_byte(CMD_R);
    tests_run++;
    if (cdc.out_ready_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL read_busy out_ready=%b expected 0", cdc.out_ready_o);
    end
    exp_q.push_back(8'h35);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    sb_drain("read_stall", 1, cyc);
  endtask

  task automatic test_version();
    int cyc;
    send_byte(CMD_V);
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h37);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    sb_drain("version", 0, cyc);
    tests_run++;
    if (cyc != 4) begin
      tests_failed++;
      $display("FAIL version_b2b cycles=%0d expected 4", cyc);
    end
  endtask

  task automatic test_bad_input();
    int cyc;
    send_byte(CMD_L);
    send_byte(8'h39);
    tests_run++;
    if (led !== 3'b101) begin
      tests_failed++;
      $display("FAIL bad_arg_led led=%b expected 101", led);
    end
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    sb_drain("bad_arg", 0, cyc);
    send_byte(8'h78);
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    sb_drain("unknown_cmd", 0, cyc);
  endtask

  task automatic test_cr_ignored();
    logic seen = 1'b0;
    send_byte(8'h0D);
    repeat (4) begin
      if (cdc.in_valid_o !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 1'b0 || dbg_state !== IDLE || cdc.out_ready_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL cr_ignored reply_seen=%b state=%0d ready=%b expected 0 0 1",
               seen, dbg_state, cdc.out_ready_o);
    end
  endtask

  task automatic test_timeout();
    int rise = -1;
    int cyc;
    send_byte(CMD_L);
    for (int k = 1; k <= 40 && rise < 0; k++) begin
      @(negedge clk);
      if (cdc.in_valid_o === 1'b1) rise = k;
    end
    tests_run++;
    if (rise != 16) begin
      tests_failed++;
      $display("FAIL timeout_cycle got=%0d expected 16", rise);
    end
    exp_q.push_back(8'h3F);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    sb_drain("timeout", 0, cyc);
  endtask

  task automatic test_timeout_byte_wins();
    int cyc;
    send_byte(CMD_L);
    repeat (15) @(negedge clk);
    send_byte(8'h33);
    tests_run++;
    if (led !== 3'b011) begin
      tests_failed++;
      $display("FAIL byte_wins_led led=%b expected 011", led);
    end
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    sb_drain("byte_wins", 0, cyc);
  endtask

  task automatic test_abort();
    int cyc;
    send_byte(CMD_L);
    send_byte(8'h36);
    cdc.in_ready_i = 1'b1;
    @(negedge clk);
    cdc.in_ready_i = 1'b0;
    configured     = 1'b0;
    #1;
    tests_run++;
    if (cdc.out_ready_o !== 1'b0 || cdc.in_valid_o !== 1'b1 || cdc.in_data_o !== 8'h0D) begin
      tests_failed++;
      $display("FAIL abort_pre ready=%b valid=%b data=%h expected 0 1 0d",
               cdc.out_ready_o, cdc.in_valid_o, cdc.in_data_o);
    end
    @(negedge clk);
    tests_run++;
    if (cdc.in_valid_o !== 1'b0 || dbg_state !== IDLE || led !== 3'b110) begin
      tests_failed++;
      $display("FAIL abort_clear valid=%b state=%0d led=%b expected 0 0 110",
               cdc.in_valid_o, dbg_state, led);
    end
    cdc.out_data_i  = CMD_L;
    cdc.out_valid_i = 1'b1;
    repeat (2) @(negedge clk);
    cdc.out_valid_i = 1'b0;
    tests_run++;
    if (dbg_state !== IDLE || cdc.out_ready_o !== 1'b0 || cdc.in_valid_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_hold state=%0d ready=%b valid=%b expected 0 0 0",
               dbg_state, cdc.out_ready_o, cdc.in_valid_o);
    end
    configured = 1'b1;
    @(negedge clk);
    send_byte(CMD_R);
    exp_q.push_back(8'h36);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    sb_drain("abort_resume", 0, cyc);
  endtask

  task automatic test_reset_mid_reply();
    int cyc;
    send_byte(CMD_V);
    cdc.in_ready_i = 1'b1;
    @(negedge clk);
    cdc.in_ready_i = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    tests_run++;
    if (cdc.in_valid_o !== 1'b0 || cdc.in_data_o !== 8'h00 || led !== 3'b000 || dbg_state !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_mid valid=%b data=%h led=%b state=%0d expected 0 00 000 0",
               cdc.in_valid_o, cdc.in_data_o, led, dbg_state);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    send_byte(CMD_R);
    exp_q.push_back(8'h30);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
    sb_drain("after_reset", 0, cyc);
  endtask

  initial begin
    test_reset();
    test_led_set();
    test_read_stall();
    test_version();
    test_bad_input();
    test_cr_ignored();
    test_timeout();
    test_timeout_byte_wins();
    test_abort();
    test_reset_mid_reply();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
